// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
// Module  : muldiv_sequencer_if
// Brief   : Request/response bundle between a pipeline and muldiv_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       funct3_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, funct3_i, src_a_i, src_b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, src_a_i, src_b_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module  : muldiv_sequencer
// Brief   : Fixed-latency iterative RV32M multiply/divide unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  muldiv_sequencer_if.slave bus
);

  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;
  logic             res_neg;
  logic             rem_neg;

  logic             is_mul;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             div_zero;
  logic             sovf;
  logic [WIDTH-1:0] fix_result;

  assign is_mul = ~op[2];
  assign a_neg  = a_lat[WIDTH-1] &
                  ((op == F_MULH) || (op == F_MULHSU) || (op == F_DIV) || (op == F_REM));
  assign b_neg  = b_lat[WIDTH-1] & ((op == F_MULH) || (op == F_DIV) || (op == F_REM));
  assign a_abs  = a_neg ? -a_lat : a_lat;
  assign b_abs  = b_neg ? -b_lat : b_lat;

  // acc:lo is the product (hi:lo) when multiplying, remainder:quotient when dividing
  assign mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
  assign div_diff = {acc, lo[WIDTH-1]} - {1'b0, opnd};
  assign div_ok   = ~div_diff[WIDTH];

  assign prod_fix = res_neg ? -{acc, lo} : {acc, lo};
  assign quo_fix  = res_neg ? -lo : lo;
  assign rem_fix  = rem_neg ? -acc : acc;
  assign div_zero = (b_lat == '0);
  assign sovf     = (a_lat == MOST_NEG) && (b_lat == '1);

  always_comb begin
    fix_result = prod_fix[WIDTH-1:0];
    case (op)
      F_MUL:                     fix_result = prod_fix[WIDTH-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      F_DIV:  fix_result = div_zero ? '1 : (sovf ? a_lat : quo_fix);
      F_DIVU: fix_result = div_zero ? '1 : lo;
      F_REM:  fix_result = div_zero ? a_lat : (sovf ? '0 : rem_fix);
      F_REMU: fix_result = div_zero ? a_lat : acc;
      default: fix_result = prod_fix[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      op           <= '0;
      a_lat        <= '0;
      b_lat        <= '0;
      opnd         <= '0;
      acc          <= '0;
      lo           <= '0;
      count        <= '0;
      res_neg      <= 1'b0;
      rem_neg      <= 1'b0;
      bus.busy_o   <= 1'b0;
      bus.done_o   <= 1'b0;
      bus.result_o <= '0;
    end else begin
      bus.done_o <= 1'b0;
      if (bus.flush_i && (state != IDLE)) begin
        state      <= IDLE;
        bus.busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start_i && !bus.flush_i) begin
              op         <= bus.funct3_i;
              a_lat      <= bus.src_a_i;
              b_lat      <= bus.src_b_i;
              bus.busy_o <= 1'b1;
              state      <= PREP;
            end
          end
          PREP: begin
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            acc     <= '0;
            lo      <= is_mul ? b_abs : a_abs;
            opnd    <= is_mul ? a_abs : b_abs;
            count   <= '0;
            state   <= CALC;
          end
          CALC: begin
            if (is_mul) begin
              acc <= mul_sum[WIDTH:1];
              lo  <= {mul_sum[0], lo[WIDTH-1:1]};
            end else begin
              acc <= div_ok ? div_diff[WIDTH-1:0] : {acc[WIDTH-2:0], lo[WIDTH-1]};
              lo  <= {lo[WIDTH-2:0], div_ok};
            end
            count <= count + CW'(1);
            if (count == LAST) begin
              state <= FIX;
            end
          end
          FIX: begin
            bus.result_o <= fix_result;
            bus.busy_o   <= 1'b0;
            bus.done_o   <= 1'b1;
            state        <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module  : tb_muldiv_sequencer
// Brief   : Directed self-checking bench for muldiv_sequencer (WIDTH = 32).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cyc = 0;
  int   prev_done;
  logic saw;
  logic [31:0] held;
  vec_t vecs[12];

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Architectural result of an RV32M operation, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] ua;
    logic        [63:0] ub;
    logic        [63:0] p;
    logic               ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * $signed(ub);  return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: phase 0 = idle, 1..W+2 = busy, W+3 = done cycle.
  int          phase   = 0;
  logic [31:0] pend    = '0;
  logic [31:0] exp_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   = 0;
      exp_res = '0;
    end else if (phase != 0 && bus.flush_i) begin
      phase = 0;
    end else if (phase == 0) begin
      if (bus.start_i && !bus.flush_i) begin
        phase = 1;
        pend  = ref_op(bus.funct3_i, bus.src_a_i, bus.src_b_i);
      end
    end else if (phase == W + 3) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == W + 3) exp_res = pend;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_model", {31'd0, bus.busy_o}, {31'd0, (phase >= 1 && phase <= W + 2)});
      check("done_model", {31'd0, bus.done_o}, {31'd0, (phase == W + 3)});
      check("result_model", bus.result_o, exp_res);
    end
  end

  task automatic issue(input vec_t v);
    bus.start_i  = 1'b1;
    bus.funct3_i = v.f;
    bus.src_a_i  = v.a;
    bus.src_b_i  = v.b;
  endtask

  task automatic finish_op(input logic [31:0] expv, input string name);
    int k;
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.src_a_i  = $urandom;
    bus.src_b_i  = $urandom;
    bus.funct3_i = 3'($urandom_range(0, 7));
    k = 1;
    while (!bus.done_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'(W + 3));
    check({name, "_result"}, bus.result_o, expv);
    done_cyc = cyc;
  endtask

  task automatic run_op(input vec_t v, input string name);
    @(negedge clk);
    issue(v);
    finish_op(v.e, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.funct3_i = '0;
    bus.src_a_i  = '0;
    bus.src_b_i  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset_done", {31'd0, bus.done_o}, 32'd0);
    check("reset_result", bus.result_o, 32'd0);

    // Start offered together with reset release: taken on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    issue(vecs[0]);
    finish_op(vecs[0].e, "vec0");
    prev_done = done_cyc;

    for (int i = 1; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      check($sformatf("b2b_gap%0d", i), 32'(done_cyc - prev_done), 32'(W + 4));
      prev_done = done_cyc;
    end

    // Flush at N+10 aborts the operation.
    @(negedge clk);
    issue('{3'd0, 32'd3, 32'd5, 32'd15});
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    held = bus.result_o;
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", {31'd0, bus.busy_o}, 32'd0);
    check("flush_result_held", bus.result_o, held);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) saw = 1'b1;
    end
    check("flush_no_done", {31'd0, saw}, 32'd0);

    // Start together with flush is dropped.
    issue('{3'd0, 32'd9, 32'd9, 32'd81});
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("start_flush_dropped", {31'd0, bus.busy_o}, 32'd0);
    @(negedge clk);
    check("start_flush_dropped2", {31'd0, bus.busy_o}, 32'd0);
    run_op('{3'd5, 32'd100, 32'd7, 32'd14}, "after_flush");

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    issue('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("async_rst_done", {31'd0, bus.done_o}, 32'd0);
    check("async_rst_result", bus.result_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (bus.done_o) saw = 1'b1;
    end
    check("rst_no_done", {31'd0, saw}, 32'd0);
    run_op('{3'd7, 32'd1000, 32'd33, 32'd10}, "after_rst");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
